// File: rtl/fifo_rr_drain_pkg.sv
// ============================================================================
// Package  : pcie_tx_pkg
// Brief    : Shared state encoding and default widths for the fifo_rr_drain slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pcie_tx_pkg;

    localparam int c_data_width = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rr_drain_if.sv
// ============================================================================
// Interface : fifo_rr_drain_if
// Brief     : Upstream FIFO read side plus downstream FIFO write/credit side.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_rr_drain_if #(
    parameter int N_CH       = 4,
    parameter int DATA_WIDTH = 6
);
    logic [N_CH-1:0]            src_empty;
    logic [N_CH-1:0]            src_alm_empty;
    logic [N_CH*DATA_WIDTH-1:0] src_data;
    logic [N_CH-1:0]            src_pop;
    logic                       credit_ret;
    logic                       dst_push;
    logic [DATA_WIDTH-1:0]      dst_data;

    modport slave (
        input  src_empty, src_alm_empty, src_data, credit_ret,
        output src_pop, dst_push, dst_data
    );

    modport master (
        output src_empty, src_alm_empty, src_data, credit_ret,
        input  src_pop, dst_push, dst_data
    );
endinterface

`default_nettype wire

// File: rtl/fifo_rr_drain_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin priority encoder; search starts at ptr+1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N_CH  = 4,
    parameter int PTR_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_CH-1:0]  grant,
    output logic [PTR_W-1:0] idx,
    output logic             found
);

    logic [PTR_W-1:0] w_k;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        w_k   = '0;
        // i == N_CH wraps back to ptr itself, so the last grantee is lowest priority
        for (int i = 1; i <= N_CH; i++) begin
            w_k = PTR_W'((int'(ptr) + i) % N_CH);
            if (!found && req[w_k]) begin
                grant[w_k] = 1'b1;
                idx        = w_k;
                found      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_rr_drain.sv
// ============================================================================
// Module   : fifo_rr_drain
// Brief    : Credit-guarded round-robin drain of N_CH upstream FIFOs into one
//            downstream FIFO. Define CH0_PRIORITY_EN to give ch0 strict priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rr_drain
    import pcie_tx_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width,
    parameter int N_CH       = 4,
    parameter int DST_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    fifo_rr_drain_if.slave        bus,
    output logic                  idle,
    output logic                  err
);

    localparam int c_ptr_w = $clog2(N_CH);
    localparam int c_crd_w = credit_width(DST_DEPTH);
    localparam logic [c_crd_w-1:0] c_full = c_crd_w'(DST_DEPTH);

    state_t                  r_state;
    logic [c_ptr_w-1:0]      r_ptr;
    logic [c_crd_w-1:0]      r_credits;
    logic [N_CH-1:0]         r_pop;
    logic [c_ptr_w-1:0]      r_pop_idx;
    logic                    r_cap_valid;
    logic [c_ptr_w-1:0]      r_cap_ch;
    logic                    r_push;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_idle;
    logic                    r_err;

    logic [N_CH-1:0]         w_req;
    logic [N_CH-1:0]         w_rr_req;
    logic [N_CH-1:0]         w_rr_grant;
    logic [c_ptr_w-1:0]      w_rr_idx;
    logic                    w_rr_found;
    logic [N_CH-1:0]         w_grant;
    logic [c_ptr_w-1:0]      w_idx;
    logic                    w_found;
    logic                    w_upd_ptr;
    logic                    w_issue;
    logic                    w_busy;
    state_t                  w_state_nx;
    logic [c_crd_w-1:0]      w_credits_nx;

    // A channel whose last entry is being popped right now still reads
    // non-empty this cycle; the alm_empty term prevents a double pop.
    assign w_req = ~bus.src_empty & ~(r_pop & bus.src_alm_empty);

`ifdef CH0_PRIORITY_EN
    assign w_rr_req = w_req & ~N_CH'(1);

    always_comb begin
        w_grant   = w_rr_grant;
        w_idx     = w_rr_idx;
        w_found   = w_rr_found;
        w_upd_ptr = 1'b1;
        if (w_req[0]) begin
            w_grant   = N_CH'(1);
            w_idx     = '0;
            w_found   = 1'b1;
            w_upd_ptr = 1'b0;
        end
    end
`else
    assign w_rr_req = w_req;

    always_comb begin
        w_grant   = w_rr_grant;
        w_idx     = w_rr_idx;
        w_found   = w_rr_found;
        w_upd_ptr = 1'b1;
    end
`endif

    rr_pick #(
        .N_CH (N_CH)
    ) u_rr_pick (
        .req   (w_rr_req),
        .ptr   (r_ptr),
        .grant (w_rr_grant),
        .idx   (w_rr_idx),
        .found (w_rr_found)
    );

    assign w_issue = (r_state == RUN) && enable && (r_credits != '0) && w_found;
    assign w_busy  = (|r_pop) || r_cap_valid || r_push;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (enable) w_state_nx = RUN;
            RUN:     if (!enable) w_state_nx = DRAIN;
            DRAIN: begin
                if (enable)       w_state_nx = RUN;
                else if (!w_busy) w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Simultaneous pop and return cancel; a return at full credit is dropped.
    always_comb begin
        w_credits_nx = r_credits;
        if (w_issue && !bus.credit_ret)
            w_credits_nx = r_credits - c_crd_w'(1);
        else if (!w_issue && bus.credit_ret && (r_credits != c_full))
            w_credits_nx = r_credits + c_crd_w'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_credits   <= c_full;
            r_pop       <= '0;
            r_pop_idx   <= '0;
            r_cap_valid <= 1'b0;
            r_cap_ch    <= '0;
            r_push      <= 1'b0;
            r_data      <= '0;
            r_idle      <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_credits   <= w_credits_nx;
            r_pop       <= w_issue ? w_grant : '0;
            r_pop_idx   <= w_idx;
            if (w_issue && w_upd_ptr)
                r_ptr <= w_idx;
            // Upstream data_out is valid the cycle after its rd_enable.
            r_cap_valid <= |r_pop;
            r_cap_ch    <= r_pop_idx;
            r_push      <= r_cap_valid;
            r_data      <= r_cap_valid ?
                           bus.src_data[int'(r_cap_ch)*DATA_WIDTH +: DATA_WIDTH] : '0;
            r_idle      <= (w_state_nx == IDLE) && !w_issue && !(|r_pop) && !r_cap_valid;
            if (bus.credit_ret && !w_issue && (r_credits == c_full))
                r_err <= 1'b1;
        end
    end

    assign bus.src_pop  = r_pop;
    assign bus.dst_push = r_push;
    assign bus.dst_data = r_data;
    assign idle         = r_idle;
    assign err          = r_err;

endmodule

`default_nettype wire
